vending_machine_param: RTL and testbench

Parametrised successor to the team's fixed-price coin vending FSM. Accumulates coin credit up to a configurable PRICE and vends once credit reaches it. Returns excess or cancelled credit one unit at a time through a valid/ready change port. Tracks product stock with restock and sold-out handling; sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vm_pkg.sv | 27 ++
 rtl/vm_stock_counter.sv | 41 ++++
 rtl/vending_machine_param.sv | 109 ++++++++++
 tb/tb_vending_machine_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and coin decoding for the parametrised vending machine.
package vm_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StVend    = 2'd2,
        StChange  = 2'd3
    } vm_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] val;
        case (code)
            COIN_1:  val = 3'd1;
            COIN_2:  val = 3'd2;
            COIN_5:  val = 3'd5;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_stock_counter.sv
// Saturating product stock register: one-unit vend decrement plus restock add.
module vm_stock_counter #(
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_i,
    input  logic               restock_valid_i,
    input  logic [STOCK_W-1:0] restock_qty_i,
    output logic [STOCK_W-1:0] stock_o,
    output logic               sold_out_o
);

    logic [STOCK_W-1:0] stock_q, stock_d;
    logic [STOCK_W:0]   sum;

    always_comb begin
        sum = {1'b0, stock_q};
        if (restock_valid_i) begin
            sum = sum + {1'b0, restock_qty_i};
        end
        // Guard against underflow even though a vend never happens with zero stock.
        if (dec_i && (stock_q != '0)) begin
            sum = sum - (STOCK_W+1)'(1);
        end
        stock_d = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stock_q <= STOCK_W'(STOCK_INIT);
        end else begin
            stock_q <= stock_d;
        end
    end

    assign stock_o    = stock_q;
    assign sold_out_o = (stock_q == '0);

endmodule

// File: rtl/vending_machine_param.sv
// Coin vending FSM with configurable price, unit-at-a-time change return and stock tracking.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 10,
    localparam int unsigned CREDIT_W  = $clog2(PRICE + 5)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid_i,
    input  logic [1:0]          coin_i,
    input  logic                cancel_i,
    input  logic                change_ready_i,
    input  logic                restock_valid_i,
    input  logic [STOCK_W-1:0]  restock_qty_i,
    output logic                product_o,
    output logic                change_valid_o,
    output logic                coin_reject_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                sold_out_o,
    output logic                busy_o
);

    localparam logic [CREDIT_W:0]   PriceWide = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PriceCr   = CREDIT_W'(PRICE);

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                accept;
    logic                vend_exit;
    logic [CREDIT_W:0]   sum;
    logic [STOCK_W-1:0]  stock_w;
    logic                sold_out_w;

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        vend_exit = 1'b0;
        accept    = coin_valid_i && (coin_i != COIN_NONE) && !sold_out_w && !cancel_i &&
                    ((state_q == StIdle) || (state_q == StCollect));
        reject_d  = coin_valid_i && !accept;
        sum       = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_i));

        case (state_q)
            StIdle, StCollect: begin
                if ((state_q == StCollect) && cancel_i) begin
                    state_d = StChange;
                end else if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = (sum >= PriceWide) ? StVend : StCollect;
                end
            end
            StVend: begin
                vend_exit = 1'b1;
                credit_d  = credit_q - PriceCr;
                state_d   = (credit_q != PriceCr) ? StChange : StIdle;
            end
            StChange: begin
                if (change_ready_i) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q <= CREDIT_W'(1)) begin
                        credit_d = '0;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    vm_stock_counter #(
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk            (clk),
        .rst            (rst),
        .dec_i          (vend_exit),
        .restock_valid_i(restock_valid_i),
        .restock_qty_i  (restock_qty_i),
        .stock_o        (stock_w),
        .sold_out_o     (sold_out_w)
    );

    assign product_o      = (state_q == StVend);
    assign change_valid_o = (state_q == StChange);
    assign busy_o         = (state_q == StVend) || (state_q == StChange);
    assign coin_reject_o  = reject_q;
    assign credit_o       = credit_q;
    assign sold_out_o     = sold_out_w;

endmodule

// File: tb/tb_vending_machine_param.sv
// Randomised and directed bench for vending_machine_param against a credit/stock reference model.
module tb_vending_machine_param;

    localparam int unsigned PRICE      = 3;
    localparam int unsigned STOCK_W    = 4;
    localparam int unsigned STOCK_INIT = 10;
    localparam int unsigned CREDIT_W   = $clog2(PRICE + 5);
    localparam int          STOCK_MAX  = (1 << STOCK_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin = 2'b00;
    logic                cancel = 1'b0;
    logic                change_ready = 1'b0;
    logic                restock_valid = 1'b0;
    logic [STOCK_W-1:0]  restock_qty = '0;
    logic                product;
    logic                change_valid;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                sold_out;
    logic                busy;

    int total = 0;
    int bad   = 0;

    // Reference model: credit and stock as plain integers plus "vend pending" / "refunding" flags.
    int m_credit;
    int m_stock;
    bit m_vend;
    bit m_refund;
    bit m_rej;

    vending_machine_param #(
        .PRICE     (PRICE),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin_valid_i   (coin_valid),
        .coin_i         (coin),
        .cancel_i       (cancel),
        .change_ready_i (change_ready),
        .restock_valid_i(restock_valid),
        .restock_qty_i  (restock_qty),
        .product_o      (product),
        .change_valid_o (change_valid),
        .coin_reject_o  (coin_reject),
        .credit_o       (credit),
        .sold_out_o     (sold_out),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("product", int'(product), int'(m_vend));
        chk("change_valid", int'(change_valid), int'(m_refund));
        chk("coin_reject", int'(coin_reject), int'(m_rej));
        chk("credit", int'(credit), m_credit);
        chk("sold_out", int'(sold_out), int'(m_stock == 0));
        chk("busy", int'(busy), int'(m_vend || m_refund));
        chk("stock", int'(dut.stock_w), m_stock);
    endtask

    function automatic int value_of(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit cv, input logic [1:0] c, input bit can, input bit rdy,
                              input bit rv, input int rq);
        bit accept;
        int dec;
        accept = cv && (value_of(c) != 0) && !m_vend && !m_refund && (m_stock != 0) && !can;
        dec = 0;
        if (m_vend) begin
            dec      = 1;
            m_credit = m_credit - int'(PRICE);
            m_vend   = 1'b0;
            m_refund = (m_credit > 0);
        end else if (m_refund) begin
            if (rdy) begin
                m_credit--;
                if (m_credit == 0) m_refund = 1'b0;
            end
        end else if (can && (m_credit > 0)) begin
            m_refund = 1'b1;
        end else if (accept) begin
            m_credit = m_credit + value_of(c);
            if (m_credit >= int'(PRICE)) m_vend = 1'b1;
        end
        m_stock = m_stock - dec + (rv ? rq : 0);
        if (m_stock > STOCK_MAX) m_stock = STOCK_MAX;
        m_rej = cv && !accept;
    endtask

    // Called at a negedge: apply inputs, update model at posedge, compare at the next negedge.
    task automatic cycle(input bit cv, input logic [1:0] c, input bit can, input bit rdy,
                         input bit rv, input int rq);
        coin_valid    = cv;
        coin          = c;
        cancel        = can;
        change_ready  = rdy;
        restock_valid = rv;
        restock_qty   = STOCK_W'(rq);
        @(posedge clk);
        model_step(cv, c, can, rdy, rv, rq);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 2'b00, 1'b0, rdy, 1'b0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_vend || m_refund) && (n < 20)) begin
            idle(1'b1);
            n++;
        end
        if (m_vend || m_refund) chk("drain_timeout", 1, 0);
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_stock  = STOCK_INIT;
        m_vend   = 1'b0;
        m_refund = 1'b0;
        m_rej    = 1'b0;
    endtask

    task automatic do_reset();
        coin_valid    = 1'b0;
        cancel        = 1'b0;
        change_ready  = 1'b0;
        restock_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic buy_three_ones();
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_credit", int'(credit), 0);
        chk("reset_stock", int'(dut.stock_w), 10);

        // Exact price with three unit coins, no change.
        buy_three_ones();
        chk("t1_product", int'(product), 1);
        drain();
        chk("t1_stock", int'(dut.stock_w), 9);

        // Two 2-unit coins: one change unit.
        cycle(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 0);
        chk("t2_credit", int'(credit), 4);
        drain();

        // 5-unit coin with hopper stalled for 3 cycles.
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        repeat (4) idle(1'b0);
        chk("t3_hold_credit", int'(credit), 2);
        drain();

        // Cancel beats a simultaneous coin.
        cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 0);
        chk("t4_reject", int'(coin_reject), 1);
        drain();
        chk("t4_stock", int'(dut.stock_w), 7);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
        end
        drain();

        // Run stock down to 1, then restock on the vend exit edge.
        do_reset();
        repeat (9) begin
            buy_three_ones();
            drain();
        end
        chk("t5_stock1", int'(dut.stock_w), 1);
        buy_three_ones();
        cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2);
        chk("t5_vend_restock", int'(dut.stock_w), 2);
        repeat (2) begin
            buy_three_ones();
            drain();
        end
        chk("t5_sold_out", int'(sold_out), 1);
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 0);
        chk("t5_so_reject", int'(coin_reject), 1);
        chk("t5_so_credit", int'(credit), 0);
        cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3);
        chk("t5_restocked", int'(dut.stock_w), 3);
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 0);
        chk("t5_accept", int'(credit), 1);

        // Reset in the middle of a stalled refund (credit 1+5-3 = 3).
        cycle(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        idle(1'b0);
        chk("t6_pre_credit", int'(credit), 3);
        chk("t6_pre_cv", int'(change_valid), 1);
        do_reset();
        chk("t6_cv", int'(change_valid), 0);
        chk("t6_stock", int'(dut.stock_w), 10);
        cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0);
        chk("t6_accept", int'(credit), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
